// File: rtl/ping_pong_display_driver.sv
// Four-digit, common-anode, time-multiplexed 7-segment driver for the ping-pong counter.
// Right two digits show the value in decimal; left two show a direction/pause glyph.
module ping_pong_display_driver #(
  parameter int SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       direction,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UP    = 7'b0011100;
  localparam logic [6:0] SEG_DOWN  = 7'b1100010;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  logic [SCAN_BITS-1:0] scan_cnt_q, scan_cnt_d;
  state_t               state_q, state_d;
  logic [3:0]           snap_val_q, snap_val_d;
  logic                 snap_dir_q, snap_dir_d;
  logic                 snap_en_q, snap_en_d;
  logic                 scan_wrap;
  logic                 tens;
  logic [3:0]           ones;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b0000001;
      4'd1:    digit_seg = 7'b1001111;
      4'd2:    digit_seg = 7'b0010010;
      4'd3:    digit_seg = 7'b0000110;
      4'd4:    digit_seg = 7'b1001100;
      4'd5:    digit_seg = 7'b0100100;
      4'd6:    digit_seg = 7'b0100000;
      4'd7:    digit_seg = 7'b0001111;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0000100;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      state_q    <= D0;
      snap_val_q <= 4'd0;
      snap_dir_q <= 1'b1;
      snap_en_q  <= 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      state_q    <= state_d;
      snap_val_q <= snap_val_d;
      snap_dir_q <= snap_dir_d;
      snap_en_q  <= snap_en_d;
    end
  end

  // Inputs are sampled only when the scan wraps back to the rightmost digit,
  // so a whole frame is always drawn from one consistent snapshot.
  always_comb begin
    scan_wrap  = &scan_cnt_q;
    scan_cnt_d = scan_cnt_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    state_d    = state_q;
    snap_val_d = snap_val_q;
    snap_dir_d = snap_dir_q;
    snap_en_d  = snap_en_q;
    if (scan_wrap) begin
      state_d = state_t'(state_q + 2'd1);
      if (state_q == D3) begin
        snap_val_d = value;
        snap_dir_d = direction;
        snap_en_d  = enable;
      end
    end
  end

  always_comb begin
    tens = (snap_val_q >= 4'd10);
    ones = tens ? (snap_val_q - 4'd10) : snap_val_q;
    an   = 4'b1111;
    seg  = SEG_BLANK;
    dp   = 1'b1;
    case (state_q)
      D0: begin
        an  = 4'b1110;
        seg = digit_seg(ones);
      end
      D1: begin
        an  = 4'b1101;
        seg = tens ? digit_seg(4'd1) : SEG_BLANK;
      end
      D2: begin
        an  = 4'b1011;
        seg = !snap_en_q ? SEG_DASH : (snap_dir_q ? SEG_UP : SEG_DOWN);
      end
      D3: begin
        an  = 4'b0111;
        seg = !snap_en_q ? SEG_DASH : (snap_dir_q ? SEG_UP : SEG_DOWN);
      end
      default: begin
        an  = 4'b1110;
        seg = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_ping_pong_display_driver.sv
// Bench for ping_pong_display_driver (SCAN_BITS=2): directed plus random stimulus,
// expected digit patterns derived from frame arithmetic and queued for a per-cycle monitor.
module tb_ping_pong_display_driver;

  localparam int SB        = 2;
  localparam int DIGIT_LEN = 1 << SB;
  localparam int FRAME_LEN = 4 * DIGIT_LEN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] value;
  logic       direction;
  logic       enable;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];

  // Reference: edges since reset and the snapshot last latched at a frame boundary
  int         k;
  logic [3:0] m_val;
  logic       m_dir;
  logic       m_en;

  logic [6:0] digit_tbl [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};

  ping_pong_display_driver #(.SCAN_BITS(SB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .direction (direction),
    .enable    (enable),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] expect_out(input int edges, input logic [3:0] v,
                                             input logic d, input logic e);
    int         pos;
    int         vi;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    pos  = (edges / DIGIT_LEN) % 4;
    vi   = int'(v);
    an_e = 4'b1111;
    an_e[pos] = 1'b0;
    case (pos)
      0:       seg_e = digit_tbl[vi % 10];
      1:       seg_e = (vi >= 10) ? digit_tbl[vi / 10] : 7'b1111111;
      default: seg_e = !e ? 7'b1111110 : (d ? 7'b0011100 : 7'b1100010);
    endcase
    return {an_e, seg_e};
  endfunction

  task automatic model_reset();
    k     = 0;
    m_val = 4'd0;
    m_dir = 1'b1;
    m_en  = 1'b1;
  endtask

  // driver: called at a negedge; drives inputs, predicts the next edge, waits a cycle
  task automatic step(input logic [3:0] v, input logic d, input logic e);
    value     = v;
    direction = d;
    enable    = e;
    if ((k + 1) % FRAME_LEN == 0) begin
      m_val = v;
      m_dir = d;
      m_en  = e;
    end
    exp_q.push_back(expect_out(k + 1, m_val, m_dir, m_en));
    k++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] v, input logic d, input logic e);
    for (int i = 0; i < n; i++) step(v, d, e);
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_an"},  32'(an),  32'(4'b1110));
    chk({tag, "_seg"}, 32'(seg), 32'(7'b0000001));
    chk({tag, "_dp"},  32'(dp),  32'd1);
  endtask

  // monitor: every cycle, compare against the queued expectation plus invariants
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an",  32'(an),  32'(e[10:7]));
        chk("seg", 32'(seg), 32'(e[6:0]));
      end
      chk("an_onehot", 32'($countones(~an)), 32'd1);
      chk("dp", 32'(dp), 32'd1);
    end
  end

  initial begin
    logic [3:0] rv;
    logic       rd, re;
    rst_n     = 1'b0;
    value     = 4'd0;
    direction = 1'b0;
    enable    = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_in_reset("reset_hold");
    end
    rst_n = 1'b1;

    // snapshot latency: first frame shows reset snapshot, value 7 from edge 16
    run(40, 4'd7, 1'b1, 1'b1);
    while ((k % FRAME_LEN) != 9) step(4'd7, 1'b1, 1'b1);

    // asynchronous reset in the middle of D2
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset("midscan_reset");
    @(negedge clk);
    check_in_reset("midscan_hold");
    model_reset();
    rst_n = 1'b1;

    run(2 * FRAME_LEN, 4'd13, 1'b0, 1'b1);
    run(2 * FRAME_LEN, 4'd9,  1'b1, 1'b1);
    run(2 * FRAME_LEN, 4'd10, 1'b0, 1'b1);
    run(2 * FRAME_LEN, 4'd15, 1'b1, 1'b1);
    run(2 * FRAME_LEN, 4'd4,  1'b1, 1'b0);

    // tearing: change 2 -> 11 while D1 is lit
    run(2 * FRAME_LEN, 4'd2, 1'b1, 1'b1);
    while ((k % FRAME_LEN) != 5) step(4'd2, 1'b1, 1'b1);
    run(FRAME_LEN + 8, 4'd11, 1'b1, 1'b1);

    // glitch: 3-cycle pulse of 5 strictly between two captures
    while ((k % FRAME_LEN) != 3) step(4'd11, 1'b1, 1'b1);
    run(3, 4'd5, 1'b1, 1'b1);
    run(2 * FRAME_LEN, 4'd11, 1'b1, 1'b1);

    // random: inputs change at arbitrary cycles
    rv = 4'($urandom_range(0, 15));
    rd = 1'($urandom_range(0, 1));
    re = 1'($urandom_range(0, 1));
    for (int i = 0; i < 30 * FRAME_LEN; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        rv = 4'($urandom_range(0, 15));
        rd = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
      end
      step(rv, rd, re);
    end

    @(posedge clk);
    #2;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ping_pong_display_driver.md
Name: ping_pong_display_driver

Overview:
- Downstream consumer of the parameterized ping-pong counter. Drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Shows the counter value `out` (0–15) as two decimal digits on the right, and the count direction as a glyph on the two left digits.
- Samples its inputs once per full scan so the displayed digits never tear mid-frame.

Parameters:
- SCAN_BITS, default 17: width of the refresh counter. Each digit is lit for 2^SCAN_BITS clk cycles. Benches use 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- value  input  4  counter value (the counter's out)
- direction  input  1  1 = counting up, 0 = counting down
- enable  input  1  counter enable; 0 = paused
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit
- seg  output  7  segments, active-low; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g
- dp  output  1  decimal point, constant 1 (off)

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - The rst_n assertion clears all state immediately, including mid-scan.
- Registers:
  - scan_cnt[SCAN_BITS-1:0]
  - digit state: D0, D1, D2, D3
  - snapshot: snap_val[3:0], snap_dir, snap_en
- Reset values:
  - scan_cnt=0, state=D0, snap_val=0, snap_dir=1, snap_en=1.
  - So during reset: an=4'b1110, seg=7'b0000001, dp=1.
- scan_cnt increments every cycle and wraps from all-ones to 0.
- State advance:
  - On the cycle scan_cnt is all-ones, the state advances D0→D1→D2→D3→D0.
  - Each digit is therefore lit for exactly 2^SCAN_BITS cycles.
- Snapshot capture:
  - Happens only on the edge where the state goes D3→D0: snap_* <= {value, direction, enable}.
  - Inputs at all other times are ignored. Pulses shorter than one frame between captures are never displayed.
- Latency: an input change becomes visible at the next D0 entry, i.e. at most 4·2^SCAN_BITS cycles later.
- Output path: an, seg and dp depend only on registers (state and snapshot). There is no combinational path from inputs to outputs.
- Exactly one an bit is low at all times, including in reset: D0=1110, D1=1101, D2=1011, D3=0111.
- Decimal split:
  - tens = (snap_val>=10) ? 1 : 0
  - ones = snap_val − 10·tens
- Per-digit content:
  - D0: ones digit.
  - D1: "1" when tens=1; blank (1111111) when snap_val<10 (leading-zero blanking).
  - D2 and D3, when snap_en=1: up glyph 0011100 (a,b,f,g) if snap_dir=1; down glyph 1100010 (c,d,e,g) if snap_dir=0.
  - D2 and D3, when snap_en=0: dash 1111110 (g only), regardless of direction.
- Digit codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- No illegal states: the 2-bit state encoding covers all four values.

Test Plan (SCAN_BITS=2: 4 cycles per digit, 16 cycles per frame):
- Reset behaviour:
  - Stimulus: hold rst_n=0 for 2 cycles, release, run 40 cycles; then assert rst_n asynchronously (between edges) while in D2.
  - Response: an=1110 and seg=0000001 throughout reset. After release, anodes step 1110,1101,1011,0111, 4 cycles each. The mid-scan assertion immediately forces an=1110 with scan_cnt=0.
- Snapshot latency:
  - Stimulus: value=7, direction=1, enable=1 applied right after reset.
  - Response: first frame shows D0=0000001, D1=1111111, D2/D3=0011100. From cycle 16 on: D0=0001111, D1=1111111.
- Two-digit value, counting down:
  - Stimulus: value=13, direction=0, enable=1.
  - Response: next frame shows D0=0000110, D1=1001111, D2=D3=1100010.
- Boundary values:
  - value=9 → D0=0000100, D1 blank.
  - value=10 → D0=0000001, D1=1001111.
  - value=15 → D0=0100100, D1=1001111.
- Pause indicator:
  - Stimulus: enable=0, direction=1, value=4.
  - Response: D2=D3=1111110, D0=1001100, D1 blank.
- Tearing and glitch immunity:
  - Stimulus: change value from 2 to 11 while in D1; separately, pulse value=5 for 3 cycles strictly between two D3→D0 edges.
  - Response: the 2→11 change does not alter the current frame; 11 appears only from the next D0. The value 5 is never displayed.
  - In all scenarios: an is always one-hot-low and dp is always 1.
